// File: rtl/spectrum_bar_engine.sv
// Spectrum bar renderer: frame-synchronous magnitude snapshot, per-bin peak hold/decay,
// and a two-stage pixel pipeline producing RGB332 for the frame buffer write port.

module spectrum_bar_peak #(
    parameter int MAG_W       = 16,
    parameter int HW          = 9,
    parameter int HOLD_W      = 5,
    parameter int V_ACTIVE    = 480,
    parameter int SHIFT       = 7,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [MAG_W-1:0] mag,
    output logic [HW-1:0]    height,
    output logic [HW-1:0]    peak
);
    logic [MAG_W-1:0]  shifted;
    logic [HW-1:0]     new_h;
    logic [HOLD_W-1:0] hold;

    always_comb begin
        shifted = mag >> SHIFT;
        new_h   = (shifted > MAG_W'(V_ACTIVE)) ? HW'(V_ACTIVE) : shifted[HW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            height <= '0;
            peak   <= '0;
            hold   <= '0;
        end else if (upd) begin
            height <= new_h;
            if (new_h >= peak) begin
                peak <= new_h;
                hold <= '0;
            end else if (hold < HOLD_W'(HOLD_FRAMES)) begin
                hold <= hold + HOLD_W'(1);
            end else begin
                // saturate at zero instead of wrapping when the step overshoots
                peak <= (peak > HW'(DECAY_STEP)) ? peak - HW'(DECAY_STEP) : '0;
            end
        end
    end
endmodule

module spectrum_bar_engine #(
    parameter int NUM_BINS    = 16,
    parameter int MAG_W       = 16,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SHIFT       = 7,
    parameter int GAP         = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                hc,
    input  logic [9:0]                vc,
    input  logic [NUM_BINS*MAG_W-1:0] mag_bus,
    input  logic [1:0]                mode,
    output logic [7:0]                pixel_color,
    output logic                      pixel_valid,
    output logic                      frame_tick
);
    localparam int BAR_W  = H_ACTIVE / NUM_BINS;
    localparam int CW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int BW     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int HW     = $clog2(V_ACTIVE + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int STAGES = 1;

    localparam logic [7:0] C_BLACK  = 8'h00;
    localparam logic [7:0] C_WHITE  = 8'hFF;
    localparam logic [7:0] C_GREEN  = 8'h1C;
    localparam logic [7:0] C_YELLOW = 8'hFC;
    localparam logic [7:0] C_RED    = 8'hE0;

    logic                         frame_start, upd;
    logic [NUM_BINS-1:0][HW-1:0]  height_arr, peak_arr;

    assign frame_start = (hc == 10'd0) && (vc == 10'(V_ACTIVE));
    assign upd         = frame_start && (mode != 2'b11);

    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
            spectrum_bar_peak #(
                .MAG_W(MAG_W), .HW(HW), .HOLD_W(HOLD_W), .V_ACTIVE(V_ACTIVE),
                .SHIFT(SHIFT), .HOLD_FRAMES(HOLD_FRAMES), .DECAY_STEP(DECAY_STEP)
            ) u_peak (
                .clk(clk), .rst(rst), .upd(upd),
                .mag(mag_bus[gi*MAG_W +: MAG_W]),
                .height(height_arr[gi]), .peak(peak_arr[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= frame_start;
    end

    // Sequential bin tracking; hc==0 restarts the line in the same cycle.
    logic [CW-1:0] col_q, cur_col;
    logic [BW-1:0] bin_q, cur_bin;

    assign cur_col = (hc == 10'd0) ? '0 : col_q;
    assign cur_bin = (hc == 10'd0) ? '0 : bin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            bin_q <= '0;
        end else if (cur_col == CW'(BAR_W - 1)) begin
            col_q <= '0;
            bin_q <= (cur_bin == BW'(NUM_BINS - 1)) ? cur_bin : cur_bin + BW'(1);
        end else begin
            col_q <= cur_col + CW'(1);
            bin_q <= cur_bin;
        end
    end

    // Stage 1: position decode
    logic              active;
    logic [STAGES:0]   vld_pipe;
    logic [9:0]        s1_row;
    logic [BW-1:0]     s1_bin;
    logic              s1_gap;
    logic [1:0]        s1_mode;

    assign active = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_row   <= '0;
            s1_bin   <= '0;
            s1_gap   <= 1'b0;
            s1_mode  <= 2'b00;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], active};
            s1_row   <= 10'(V_ACTIVE - 1) - vc;
            s1_bin   <= cur_bin;
            s1_gap   <= cur_col >= CW'(BAR_W - GAP);
            s1_mode  <= mode;
        end
    end

    // Stage 2: colour select
    logic [9:0] h_sel, p_sel;
    logic       is_peak, is_bar;
    logic [7:0] color_nx;

    always_comb begin
        h_sel    = 10'(height_arr[s1_bin]);
        p_sel    = 10'(peak_arr[s1_bin]);
        is_peak  = (s1_mode != 2'b00) && (p_sel != 10'd0) && (s1_row < p_sel)
                   && ({1'b0, s1_row} + 11'd2 >= {1'b0, p_sel});
        is_bar   = (s1_mode != 2'b10) && (s1_row < h_sel);
        color_nx = C_BLACK;
        if (vld_pipe[0] && !s1_gap) begin
            if (is_peak)
                color_nx = C_WHITE;
            else if (is_bar) begin
                if (s1_row < 10'(V_ACTIVE / 3))          color_nx = C_GREEN;
                else if (s1_row < 10'(2 * V_ACTIVE / 3)) color_nx = C_YELLOW;
                else                                     color_nx = C_RED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pixel_color <= 8'h00;
        else     pixel_color <= color_nx;
    end

    assign pixel_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_spectrum_bar_engine.sv
// Directed bench for spectrum_bar_engine: drives hc/vc directly, scans selected lines
// and compares pixels two cycles behind the counters.

module tb_spectrum_bar_engine;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   hc = 10'd700;
    logic [9:0]   vc = 10'd500;
    logic [255:0] mag_bus = '0;
    logic [1:0]   mode = 2'b00;
    logic [7:0]   pixel_color;
    logic         pixel_valid;
    logic         frame_tick;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] lc [0:639];
    logic       lv [0:639];
    logic       tick_hi, tick_lo;

    spectrum_bar_engine dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc), .mag_bus(mag_bus), .mode(mode),
        .pixel_color(pixel_color), .pixel_valid(pixel_valid), .frame_tick(frame_tick)
    );

    always #20 clk = ~clk;

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic set_mag(input int bin, input logic [15:0] m);
        mag_bus[bin*16 +: 16] = m;
    endtask

    // output sampled at iteration i belongs to the pixel driven at iteration i-2
    task automatic scan_line(input int v);
        for (int i = 0; i < 642; i++) begin
            step;
            if (i >= 2) begin
                lc[i-2] = pixel_color;
                lv[i-2] = pixel_valid;
            end
            hc = 10'(i);
            vc = 10'(v);
        end
        hc = 10'd700; vc = 10'd500;
    endtask

    task automatic tick;
        step; hc = 10'd0; vc = 10'd480;
        step; tick_hi = frame_tick; hc = 10'd1;
        step; tick_lo = frame_tick; hc = 10'd700; vc = 10'd500;
    endtask

    task automatic test_reset;
        #5;
        total_cnt++; if (pixel_color !== 8'h00) $display("FAIL rst_color got %h exp 00", pixel_color); else pass_cnt++;
        total_cnt++; if (pixel_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", pixel_valid); else pass_cnt++;
        total_cnt++; if (frame_tick !== 1'b0) $display("FAIL rst_tick got %b exp 0", frame_tick); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_snapshot;
        mode = 2'b00;
        set_mag(3, 16'h1900);
        tick;
        total_cnt++; if (tick_hi !== 1'b1) $display("FAIL snap_tick_hi got %b exp 1", tick_hi); else pass_cnt++;
        total_cnt++; if (tick_lo !== 1'b0) $display("FAIL snap_tick_lo got %b exp 0", tick_lo); else pass_cnt++;
        scan_line(469);
        total_cnt++; if (lc[120] !== 8'h1C) $display("FAIL snap_c120 got %h exp 1c", lc[120]); else pass_cnt++;
        total_cnt++; if (lc[155] !== 8'h1C) $display("FAIL snap_c155 got %h exp 1c", lc[155]); else pass_cnt++;
        total_cnt++; if (lc[156] !== 8'h00) $display("FAIL snap_gap156 got %h exp 00", lc[156]); else pass_cnt++;
        total_cnt++; if (lc[159] !== 8'h00) $display("FAIL snap_gap159 got %h exp 00", lc[159]); else pass_cnt++;
        total_cnt++; if (lc[119] !== 8'h00) $display("FAIL snap_c119 got %h exp 00", lc[119]); else pass_cnt++;
        total_cnt++; if (lc[160] !== 8'h00) $display("FAIL snap_c160 got %h exp 00", lc[160]); else pass_cnt++;
        total_cnt++; if (lv[120] !== 1'b1) $display("FAIL snap_vld got %b exp 1", lv[120]); else pass_cnt++;
        scan_line(430);
        total_cnt++; if (lc[120] !== 8'h1C) $display("FAIL snap_row49 got %h exp 1c", lc[120]); else pass_cnt++;
        scan_line(429);
        total_cnt++; if (lc[120] !== 8'h00) $display("FAIL snap_row50 got %h exp 00", lc[120]); else pass_cnt++;
    endtask

    task automatic test_ramp;
        set_mag(0, 16'hFFFF);
        tick;
        scan_line(479);
        total_cnt++; if (lc[0] !== 8'h1C) $display("FAIL ramp_row0 got %h exp 1c", lc[0]); else pass_cnt++;
        scan_line(320);
        total_cnt++; if (lc[5] !== 8'h1C) $display("FAIL ramp_row159 got %h exp 1c", lc[5]); else pass_cnt++;
        scan_line(319);
        total_cnt++; if (lc[5] !== 8'hFC) $display("FAIL ramp_row160 got %h exp fc", lc[5]); else pass_cnt++;
        scan_line(160);
        total_cnt++; if (lc[5] !== 8'hFC) $display("FAIL ramp_row319 got %h exp fc", lc[5]); else pass_cnt++;
        scan_line(159);
        total_cnt++; if (lc[5] !== 8'hE0) $display("FAIL ramp_row320 got %h exp e0", lc[5]); else pass_cnt++;
        scan_line(0);
        total_cnt++; if (lc[35] !== 8'hE0) $display("FAIL ramp_row479 got %h exp e0", lc[35]); else pass_cnt++;
        total_cnt++; if (lc[36] !== 8'h00) $display("FAIL ramp_gap got %h exp 00", lc[36]); else pass_cnt++;
    endtask

    task automatic test_blanking;
        int bad;
        set_mag(0, 16'h0000);
        scan_line(0);
        total_cnt++; if (lc[0] !== 8'hE0) $display("FAIL blank_midframe got %h exp e0", lc[0]); else pass_cnt++;
        scan_line(500);
        bad = 0;
        for (int i = 0; i < 640; i++) if (lc[i] !== 8'h00 || lv[i] !== 1'b0) bad++;
        total_cnt++; if (bad !== 0) $display("FAIL blank_vline got %0d nonblank exp 0", bad); else pass_cnt++;
        bad = 0;
        for (int i = 640; i < 802; i++) begin
            step;
            if (i >= 642 && (pixel_color !== 8'h00 || pixel_valid !== 1'b0)) bad++;
            hc = (i > 799) ? 10'd799 : 10'(i);
            vc = 10'd10;
        end
        hc = 10'd700; vc = 10'd500;
        total_cnt++; if (bad !== 0) $display("FAIL blank_hblank got %0d nonblank exp 0", bad); else pass_cnt++;
    endtask

    task automatic test_peak;
        mode = 2'b01;
        mag_bus = '0;
        set_mag(5, 16'h3200);
        set_mag(6, 16'h0080);
        tick;
        scan_line(380);
        total_cnt++; if (lc[200] !== 8'hFF) $display("FAIL peak_row99 got %h exp ff", lc[200]); else pass_cnt++;
        scan_line(381);
        total_cnt++; if (lc[200] !== 8'hFF) $display("FAIL peak_row98 got %h exp ff", lc[200]); else pass_cnt++;
        scan_line(382);
        total_cnt++; if (lc[200] !== 8'h1C) $display("FAIL peak_row97 got %h exp 1c", lc[200]); else pass_cnt++;
        scan_line(379);
        total_cnt++; if (lc[200] !== 8'h00) $display("FAIL peak_row100 got %h exp 00", lc[200]); else pass_cnt++;
        scan_line(479);
        total_cnt++; if (lc[240] !== 8'hFF) $display("FAIL peak1_row0 got %h exp ff", lc[240]); else pass_cnt++;
        scan_line(478);
        total_cnt++; if (lc[240] !== 8'h00) $display("FAIL peak1_row1 got %h exp 00", lc[240]); else pass_cnt++;
        mag_bus = '0;
        for (int i = 0; i < 30; i++) tick;
        scan_line(380);
        total_cnt++; if (lc[200] !== 8'hFF) $display("FAIL hold_row99 got %h exp ff", lc[200]); else pass_cnt++;
        scan_line(382);
        total_cnt++; if (lc[200] !== 8'h00) $display("FAIL hold_nobar got %h exp 00", lc[200]); else pass_cnt++;
        tick;
        scan_line(384);
        total_cnt++; if (lc[200] !== 8'hFF) $display("FAIL decay_row95 got %h exp ff", lc[200]); else pass_cnt++;
        scan_line(380);
        total_cnt++; if (lc[200] !== 8'h00) $display("FAIL decay_row99 got %h exp 00", lc[200]); else pass_cnt++;
        for (int i = 0; i < 23; i++) tick;
        scan_line(476);
        total_cnt++; if (lc[200] !== 8'hFF) $display("FAIL decay_row3 got %h exp ff", lc[200]); else pass_cnt++;
        scan_line(475);
        total_cnt++; if (lc[200] !== 8'h00) $display("FAIL decay_row4 got %h exp 00", lc[200]); else pass_cnt++;
        tick;
        tick;
        scan_line(479);
        total_cnt++; if (lc[200] !== 8'h00) $display("FAIL decay_zero_r0 got %h exp 00", lc[200]); else pass_cnt++;
        scan_line(478);
        total_cnt++; if (lc[200] !== 8'h00) $display("FAIL decay_zero_r1 got %h exp 00", lc[200]); else pass_cnt++;
    endtask

    task automatic test_freeze;
        mode = 2'b01;
        set_mag(8, 16'h6400);
        tick;
        mode = 2'b11;
        set_mag(8, 16'h1000);
        tick;
        total_cnt++; if (tick_hi !== 1'b1) $display("FAIL frz_tick got %b exp 1", tick_hi); else pass_cnt++;
        set_mag(8, 16'hFFFF);
        tick;
        set_mag(8, 16'h0000);
        tick;
        scan_line(280);
        total_cnt++; if (lc[320] !== 8'hFF) $display("FAIL frz_peak got %h exp ff", lc[320]); else pass_cnt++;
        scan_line(329);
        total_cnt++; if (lc[320] !== 8'h1C) $display("FAIL frz_row150 got %h exp 1c", lc[320]); else pass_cnt++;
        scan_line(299);
        total_cnt++; if (lc[320] !== 8'hFC) $display("FAIL frz_row180 got %h exp fc", lc[320]); else pass_cnt++;
        scan_line(229);
        total_cnt++; if (lc[320] !== 8'h00) $display("FAIL frz_row250 got %h exp 00", lc[320]); else pass_cnt++;
        mode = 2'b01;
        set_mag(8, 16'hFFFF);
        tick;
        scan_line(229);
        total_cnt++; if (lc[320] !== 8'hFC) $display("FAIL unfrz_row250 got %h exp fc", lc[320]); else pass_cnt++;
        scan_line(0);
        total_cnt++; if (lc[320] !== 8'hFF) $display("FAIL unfrz_peak479 got %h exp ff", lc[320]); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 50; i++) begin
            step;
            hc = 10'(i); vc = 10'd0;
        end
        step; step;
        total_cnt++; if (pixel_valid !== 1'b1) $display("FAIL rstmid_pre got %b exp 1", pixel_valid); else pass_cnt++;
        #5 rst = 1'b1;
        #1;
        total_cnt++; if (pixel_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", pixel_valid); else pass_cnt++;
        total_cnt++; if (pixel_color !== 8'h00) $display("FAIL rstmid_color got %h exp 00", pixel_color); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        hc = 10'd700; vc = 10'd500;
        scan_line(229);
        total_cnt++; if (lc[320] !== 8'h00) $display("FAIL rstmid_bar got %h exp 00", lc[320]); else pass_cnt++;
        scan_line(0);
        total_cnt++; if (lc[320] !== 8'h00) $display("FAIL rstmid_peak got %h exp 00", lc[320]); else pass_cnt++;
        tick;
        scan_line(229);
        total_cnt++; if (lc[320] !== 8'hFC) $display("FAIL rstmid_resume got %h exp fc", lc[320]); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_snapshot;
        test_ramp;
        test_blanking;
        test_peak;
        test_freeze;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spectrum_bar_engine.md
Name: spectrum_bar_engine

Overview:
Parametrised successor to the fixed 16-bin bar renderer in the VGA path. Takes the packed per-bin magnitude bus and the VGA timing counters, and produces one RGB332 colour per pixel for the frame buffer write port. Adds frame-synchronous magnitude snapshotting, per-bin peak-hold with timed decay, a height-graded colour ramp, and selectable display modes. Sits between the audio analysis output and the frame buffer, in the 25 MHz VGA clock domain.

Parameters:
NUM_BINS, 16, number of frequency bins (bars); H_ACTIVE must be divisible by NUM_BINS
MAG_W, 16, width of each bin magnitude
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SHIFT, 7, right shift that converts a magnitude to a bar height in pixels
GAP, 4, black columns at the right edge of each bar slot (must be less than H_ACTIVE/NUM_BINS)
HOLD_FRAMES, 30, frames a peak is held before it starts to decay
DECAY_STEP, 4, pixels the peak drops per frame once decaying

Ports:
clk  in  1  VGA pixel clock (25 MHz)
rst  in  1  asynchronous reset, active-high
hc  in  10  horizontal counter from the timing generator
vc  in  10  vertical counter from the timing generator
mag_bus  in  NUM_BINS*MAG_W  packed magnitudes; bin i is at [i*MAG_W +: MAG_W]; bin 0 is the leftmost bar
mode  in  2  00 bars, 01 bars+peaks, 10 peaks only, 11 freeze (bars+peaks, no updates)
pixel_color  out  8  RGB332 colour {r[2:0],g[2:0],b[1:0]}
pixel_valid  out  1  pixel_color corresponds to a visible pixel
frame_tick  out  1  one-cycle pulse when the snapshot/peak update happens

Behaviour:
- Reset is asynchronous and active-high: pixel_color=0, pixel_valid=0, frame_tick=0, all heights, peaks and hold counters 0, and the pipeline is cleared.
- Derived values: BAR_W = H_ACTIVE/NUM_BINS; row_up = V_ACTIVE-1-vc (the row counted up from the bottom).
- Frame start is the cycle where hc==0 && vc==V_ACTIVE (first blanking line). On the next clock edge, unless mode==11:
  - height[i] = min(mag[i] >> SHIFT, V_ACTIVE);
  - if the new height >= peak[i]: peak[i] = new height and hold[i] = 0;
  - else if hold[i] < HOLD_FRAMES: hold[i] increments;
  - else peak[i] = max(peak[i] - DECAY_STEP, 0), saturating at 0 with no wrap.
- frame_tick pulses for one cycle with that update. In freeze mode frame_tick still pulses, but heights, peaks and hold counters keep their values.
- Heights are never updated mid-frame; mag_bus changes during the active area have no visible effect.
- Bin tracking is sequential, with no divider:
  - bin_idx and col_in_bin reset to 0 when hc==0;
  - col_in_bin increments each cycle and wraps at BAR_W-1, at which point bin_idx increments;
  - bin_idx saturates at NUM_BINS-1.
- Pipeline, latency 2 cycles: a pixel at (hc,vc) presented at edge N appears on pixel_color/pixel_valid after edge N+2.
  - Stage 1 registers the active flag, row_up, bin_idx and the gap flag (col_in_bin >= BAR_W-GAP).
  - Stage 2 muxes the colour.
- Active flag = (hc < H_ACTIVE) && (vc < V_ACTIVE). When the pixel is inactive: pixel_valid=0 and pixel_color=0.
- Colour priority for an active pixel:
  1. gap column: black 8'h00;
  2. peak, when mode is not 00, peak>0, and row_up is in [peak-2, peak-1]: white 8'hFF;
  3. bar, when mode is not 10 and row_up < height: graded colour —
     - row_up < V_ACTIVE/3: green 8'h1C;
     - row_up < 2*V_ACTIVE/3: yellow 8'hFC;
     - otherwise: red 8'hE0;
  4. otherwise black.
- Peak is drawn 2 rows thick. When peak==1 only row 0 is drawn.
- A height of 0 draws nothing. A height of V_ACTIVE fills the full column.
- A reset in the middle of a frame blanks the output immediately. Normal output resumes from the next counter values, and bars stay empty until the next frame start.

Test Plan:
- Reset: assert rst mid-line with non-zero state -> pixel_color=0, pixel_valid=0 asynchronously; heights and peaks read 0, so the next frame is all black.
- Snapshot/latency: bin 3 mag=16'h1900 (height 50), frame start, then scan the next frame -> at hc=120..155 pixels with row_up<50 are green 8'h1C, exactly 2 cycles after hc/vc; hc=156..159 are black (gap).
- Saturation/ramp: bin 0 mag=16'hFFFF -> height 480 (clamped from 511); row_up 0..159 green, 160..319 yellow, 320..479 red.
- Peak hold/decay (mode 01): bin 5 height 100 for one frame, then mag=0 -> white rows 98..99 held for 30 frame_ticks, then the peak drops 4 per frame (96, 92, ...) and reaches 0 with no wrap.
- Freeze (mode 11): change mag_bus across 3 frames -> frame_tick still pulses and the rendered image is unchanged; returning to mode 01 updates at the next frame start.
- Blanking: hc=640..799 or vc=480..524 -> pixel_valid=0, pixel_color=0; changing mag_bus mid-frame causes no change until frame start.
